// File: rtl/mem_port_requester.sv
// mem_port_requester: in-order read/write requester for one memory port with credit-protected read responses
module mem_port_requester #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 32,
  parameter int CMD_DEPTH  = 4,
  parameter int RSP_DEPTH  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_we,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic [ADDR_WIDTH-1:0] r_addr,
  output logic                  r_avalid,
  input  logic                  r_aready,
  input  logic                  r_dvalid,
  input  logic [DATA_WIDTH-1:0] r_data,
  output logic [ADDR_WIDTH-1:0] w_addr,
  output logic [DATA_WIDTH-1:0] w_data,
  output logic                  w_valid,
  input  logic                  w_ready,
  output logic                  busy,
  output logic                  err_unexp
);
  localparam int CA = $clog2(CMD_DEPTH);
  localparam int RA = $clog2(RSP_DEPTH);
  localparam int CW = CA + 1;
  localparam int RW = RA + 1;
  localparam logic [RA:0] RSP_FULL = RW'(RSP_DEPTH);

  typedef enum logic [1:0] {IDLE, ISSUE, STALL} state_t;
  state_t state;

  logic                  cq_we   [CMD_DEPTH];
  logic [ADDR_WIDTH-1:0] cq_addr [CMD_DEPTH];
  logic [DATA_WIDTH-1:0] cq_data [CMD_DEPTH];
  logic [DATA_WIDTH-1:0] rsp_mem [RSP_DEPTH];

  logic [CA:0] cwp, crp, crp_n;
  logic [RA:0] rwp, rrp, outstanding, rsp_count, out_n, cnt_n;
  logic cmd_empty, cmd_full, cmd_push, r_hs, w_hs, hs, dv_ok, rsp_pop;
  logic head_we, head_we_n, credit_ok, load, act_n;

  // FIFO status, handshakes, credit check and next-cycle counts
  always_comb begin
    cmd_empty = cwp == crp;
    cmd_full  = (cwp[CA] != crp[CA]) && (cwp[CA-1:0] == crp[CA-1:0]);
    cmd_ready = !cmd_full;
    cmd_push  = cmd_valid && !cmd_full;
    r_hs      = r_avalid && r_aready;
    w_hs      = w_valid && w_ready;
    hs        = r_hs || w_hs;
    dv_ok     = r_dvalid && outstanding != '0;
    rsp_valid = rwp != rrp;
    rsp_pop   = rsp_valid && rsp_ready;
    rsp_data  = rsp_valid ? rsp_mem[rrp[RA-1:0]] : '0;
    rsp_count = rwp - rrp;
    head_we   = cq_we[crp[CA-1:0]];
    credit_ok = (outstanding + rsp_count) < RSP_FULL;
    load      = !r_avalid && !w_valid && !cmd_empty && (head_we || credit_ok);
    busy      = state != IDLE || outstanding != '0;
    crp_n     = crp + CW'(hs);
    out_n     = outstanding + RW'(r_hs) - RW'(dv_ok);
    cnt_n     = rsp_count + RW'(dv_ok) - RW'(rsp_pop);
    act_n     = load || ((r_avalid || w_valid) && !hs);
    head_we_n = (crp_n == cwp) ? cmd_we : cq_we[crp_n[CA-1:0]];
  end

  // Command and response storage; credits guarantee a free response slot on every accepted r_dvalid
  always_ff @(posedge clk) begin
    if (cmd_push) begin
      cq_we[cwp[CA-1:0]]   <= cmd_we;
      cq_addr[cwp[CA-1:0]] <= cmd_addr;
      cq_data[cwp[CA-1:0]] <= cmd_wdata;
    end
    if (dv_ok) rsp_mem[rwp[RA-1:0]] <= r_data;
  end

  // Pointers, outstanding-read counter and the sticky unexpected-data flag
  always_ff @(posedge clk) begin
    if (rst) begin
      cwp         <= '0;
      crp         <= '0;
      rwp         <= '0;
      rrp         <= '0;
      outstanding <= '0;
      err_unexp   <= 1'b0;
    end else begin
      cwp         <= cwp + CW'(cmd_push);
      crp         <= crp_n;
      rwp         <= rwp + RW'(dv_ok);
      rrp         <= rrp + RW'(rsp_pop);
      outstanding <= out_n;
      err_unexp   <= err_unexp || (r_dvalid && outstanding == '0);
    end
  end

  // Issue registers: load the head when idle on the port, hold until the handshake, then drop for one cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      r_avalid <= 1'b0;
      w_valid  <= 1'b0;
      r_addr   <= '0;
      w_addr   <= '0;
      w_data   <= '0;
    end else if (load) begin
      r_avalid <= !head_we;
      w_valid  <= head_we;
      r_addr   <= cq_addr[crp[CA-1:0]];
      w_addr   <= cq_addr[crp[CA-1:0]];
      w_data   <= cq_data[crp[CA-1:0]];
    end else if (hs) begin
      r_avalid <= 1'b0;
      w_valid  <= 1'b0;
    end
  end

  // Controller state: idle when the queue drains, stall when the head read has no credit
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else state <= (crp_n == cwp + CW'(cmd_push)) ? IDLE :
                  (!act_n && !head_we_n && (out_n + cnt_n) == RSP_FULL) ? STALL : ISSUE;
  end
endmodule

// File: tb/tb_mem_port_requester.sv
// tb_mem_port_requester: randomized and directed scoreboard bench for mem_port_requester
module tb_mem_port_requester;
  logic clk = 0, rst = 1;
  logic cmd_valid = 0, cmd_ready, cmd_we = 0;
  logic [3:0] cmd_addr = 0;
  logic [31:0] cmd_wdata = 0;
  logic rsp_valid, rsp_ready = 0;
  logic [31:0] rsp_data;
  logic [3:0] r_addr, w_addr;
  logic r_avalid, r_aready = 0, r_dvalid = 0, w_valid, w_ready = 0, busy, err_unexp;
  logic [31:0] r_data = 0, w_data;

  mem_port_requester dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .r_addr(r_addr), .r_avalid(r_avalid), .r_aready(r_aready),
    .r_dvalid(r_dvalid), .r_data(r_data), .w_addr(w_addr), .w_data(w_data), .w_valid(w_valid),
    .w_ready(w_ready), .busy(busy), .err_unexp(err_unexp)
  );

  always #5 clk = ~clk;

  int vec = 0, mis = 0;
  logic [31:0] ref_mem [16];
  logic [31:0] mem_arr [16];
  logic [31:0] exp_q [$];
  logic [31:0] pend [$];
  int outs = 0, rsp_n = 0, cmd_n = 0, n_rhs = 0;
  bit exp_err = 0, acc = 0;
  int ar_p = 100, w_p = 100, dv_p = 100, rr_p = 100;
  bit s_valid = 0, s_we = 0, s_rst = 1;
  logic [3:0] s_addr = 0;
  logic [31:0] s_wdata = 0;
  bit prev_rheld = 0, prev_wheld = 0, prev_dvok = 0;
  logic [3:0] prev_raddr, prev_waddr;
  logic [31:0] prev_wdata;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    vec++;
    if (act !== exp) begin
      mis++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic timeout(string nm);
    vec++;
    mis++;
    $display("FAIL %s: timed out", nm);
  endtask

  // one clock: drive inputs at negedge, then account for the handshakes the next posedge will see
  task automatic step();
    @(negedge clk);
    rst = s_rst; cmd_valid = s_valid; cmd_we = s_we; cmd_addr = s_addr; cmd_wdata = s_wdata;
    r_aready = !s_rst && $urandom_range(99) < ar_p;
    w_ready = !s_rst && $urandom_range(99) < w_p;
    rsp_ready = $urandom_range(99) < rr_p;
    r_dvalid = pend.size() > 0 && $urandom_range(99) < dv_p;
    r_data = r_dvalid ? pend[0] : $urandom;
    #1;
    chk("exclusive", {31'b0, r_avalid & w_valid}, 0);
    chk("err_unexp", {31'b0, err_unexp}, {31'b0, exp_err});
    if (prev_rheld) chk("r_hold", {27'b0, r_avalid, r_addr}, {27'b0, 1'b1, prev_raddr});
    if (prev_wheld) chk("w_hold", {27'b0, w_valid, w_addr} ^ w_data, {27'b0, 1'b1, prev_waddr} ^ prev_wdata);
    if (prev_dvok) chk("rsp_latency", {31'b0, rsp_valid}, 1);
    prev_dvok = 0;
    acc = cmd_valid && cmd_ready && !rst;
    if (r_dvalid) void'(pend.pop_front());
    if (rst) begin
      exp_q.delete(); outs = 0; rsp_n = 0; cmd_n = 0; exp_err = 0; ref_mem = mem_arr;
    end else begin
      if (acc) begin
        cmd_n++;
        if (cmd_we) ref_mem[cmd_addr] = cmd_wdata;
        else exp_q.push_back(ref_mem[cmd_addr]);
      end
      if (r_dvalid) begin
        if (outs > 0) begin outs--; rsp_n++; prev_dvok = 1; end
        else exp_err = 1;
      end
      if (w_valid && w_ready) begin mem_arr[w_addr] = w_data; cmd_n--; end
      if (r_avalid && r_aready) begin pend.push_back(mem_arr[r_addr]); outs++; cmd_n--; n_rhs++; end
      if (rsp_valid && rsp_ready) rsp_n--;
      chk("credit", {31'b0, outs + rsp_n <= 4}, 1);
    end
    prev_rheld = r_avalid && !r_aready && !rst;
    prev_wheld = w_valid && !w_ready && !rst;
    prev_raddr = r_addr; prev_waddr = w_addr; prev_wdata = w_data;
  endtask

  task automatic push(bit we, logic [3:0] a, logic [31:0] d);
    s_valid = 1; s_we = we; s_addr = a; s_wdata = d;
    for (int i = 0; i < 300; i++) begin
      step();
      if (acc) begin s_valid = 0; return; end
    end
    s_valid = 0;
    timeout("push");
  endtask

  task automatic drain();
    ar_p = 100; w_p = 100; dv_p = 100; rr_p = 100;
    for (int i = 0; i < 3000; i++) begin
      if (cmd_n == 0 && outs == 0 && rsp_n == 0 && exp_q.size() == 0) return;
      step();
    end
    timeout("drain");
  endtask

  // response monitor: pops the scoreboard whenever the client takes a response
  always @(negedge clk) begin
    #2;
    if (!rst && rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) begin
        vec++; mis++;
        $display("FAIL rsp_unexpected: got %h expected none", rsp_data);
      end else chk("rsp_data", rsp_data, exp_q.pop_front());
    end
  end

  initial begin
    int h0;
    for (int i = 0; i < 16; i++) begin mem_arr[i] = 0; ref_mem[i] = 0; end
    repeat (3) step();
    s_rst = 0;
    step();
    chk("rst_cmd_ready", {31'b0, cmd_ready}, 1);
    chk("rst_valids", {28'b0, rsp_valid, r_avalid, w_valid, busy}, 0);
    chk("rst_err", {31'b0, err_unexp}, 0);
    chk("rst_data", rsp_data | w_data | {24'b0, r_addr, w_addr}, 0);

    push(1, 3, 32'hDEADBEEF);
    push(0, 3, 0);
    drain();
    chk("wr_rd_mem", mem_arr[3], 32'hDEADBEEF);

    ar_p = 0; w_p = 0;
    for (int i = 0; i < 4; i++) push(0, 4'(i), 0);
    step();
    chk("bp_full", {31'b0, cmd_ready}, 0);
    h0 = n_rhs;
    s_valid = 1; s_we = 0; s_addr = 7;
    for (int i = 0; i < 3; i++) begin step(); chk("bp_refused", {31'b0, acc}, 0); end
    ar_p = 100;
    for (int i = 0; i < 50 && !acc; i++) step();
    s_valid = 0;
    if (!acc) timeout("bp_accept");
    chk("bp_after_hs", {31'b0, n_rhs - h0 >= 1}, 1);
    drain();

    ar_p = 100; dv_p = 100; rr_p = 0;
    h0 = n_rhs;
    for (int i = 0; i < 6; i++) push(0, 4'($urandom_range(15)), 0);
    repeat (12) step();
    chk("stall_hs", n_rhs - h0, 4);
    chk("stall_credits", outs + rsp_n, 4);
    chk("stall_busy", {30'b0, busy, rsp_valid}, 3);
    rr_p = 100; step(); rr_p = 0;
    repeat (8) step();
    chk("stall_release", n_rhs - h0, 5);
    drain();

    ar_p = 50; w_p = 50; dv_p = 50; rr_p = 50;
    for (int i = 0; i < 8; i++) push(i % 2 == 0, 4'(i / 2), $urandom);
    drain();

    for (int i = 0; i < 300; i++) begin
      if (i % 25 == 0) begin
        ar_p = $urandom_range(100, 20); w_p = $urandom_range(100, 20);
        dv_p = $urandom_range(100, 20); rr_p = $urandom_range(100, 30);
      end
      push($urandom_range(1), 4'($urandom_range(15)), $urandom);
      repeat ($urandom_range(2)) step();
    end
    drain();

    ar_p = 100; dv_p = 0; rr_p = 100;
    push(0, 1, 0);
    push(0, 2, 0);
    for (int i = 0; i < 50 && outs < 2; i++) step();
    chk("inflight", outs, 2);
    s_rst = 1; step(); s_rst = 0; step();
    chk("mid_rst_ready", {31'b0, cmd_ready}, 1);
    chk("mid_rst_idle", {29'b0, rsp_valid, r_avalid, busy}, 0);
    dv_p = 100;
    repeat (4) step();
    chk("mid_rst_err", {31'b0, err_unexp}, 1);
    chk("mid_rst_no_rsp", {31'b0, rsp_valid}, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vec, mis);
    $finish;
  end
endmodule
